// File: rtl/idli_sqi_mem_m.sv
// SQI serial-memory responder: accepts READ (0x03) / WRITE (0x02) transactions
// nibble by nibble on one chip-select lane and serves them from an internal byte array.
module idli_sqi_mem_m #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    typedef enum logic [2:0] {
        S_CMD    = 3'd0,
        S_ADDR   = 3'd1,
        S_DUMMY  = 3'd2,
        S_RD     = 3'd3,
        S_WR     = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [23:0]   addr_q, addr_d;
    logic [3:0]    nib_q, nib_d;
    logic          rd_q, rd_d;
    logic [3:0]    sio_q, sio_d;
    logic          oe_q, oe_d;
    logic          we;
    logic [7:0]    wdata;
    logic [AW-1:0] addr_inc;
    logic [7:0]    cur_byte;
    logic [7:0]    nxt_byte;

    logic [7:0] mem [DEPTH];

    // Only the low AW address bits select storage; the upper bits just shift through.
    assign addr_inc = addr_q[AW-1:0] + 1'b1;
    assign cur_byte = mem[addr_q[AW-1:0]];
    assign nxt_byte = mem[addr_inc];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        nib_d   = nib_q;
        rd_d    = rd_q;
        sio_d   = sio_q;
        oe_d    = oe_q;
        we      = 1'b0;
        wdata   = {nib_q, i_mem_sio};

        if (i_mem_cs) begin
            // Deselect wins over any nibble on the same edge.
            state_d = S_CMD;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else if (i_mem_sck) begin
            case (state_q)
                S_CMD: begin
                    if (cnt_q == 3'd0) begin
                        nib_d = i_mem_sio;
                        cnt_d = 3'd1;
                    end else begin
                        cnt_d = 3'd0;
                        if ({nib_q, i_mem_sio} == 8'h03 || {nib_q, i_mem_sio} == 8'h02) begin
                            state_d = S_ADDR;
                            rd_d    = (i_mem_sio == 4'h3);
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR: begin
                    addr_d = {addr_q[19:0], i_mem_sio};
                    if (cnt_q == 3'd5) begin
                        cnt_d   = 3'd0;
                        state_d = rd_q ? S_DUMMY : S_WR;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_DUMMY: begin
                    if (cnt_q == 3'd0) begin
                        cnt_d = 3'd1;
                    end else begin
                        // Preload the first data nibble so it is on the bus by the next sck.
                        cnt_d   = 3'd0;
                        state_d = S_RD;
                        oe_d    = 1'b1;
                        sio_d   = cur_byte[7:4];
                    end
                end
                S_RD: begin
                    if (cnt_q == 3'd0) begin
                        cnt_d = 3'd1;
                        sio_d = cur_byte[3:0];
                    end else begin
                        cnt_d  = 3'd0;
                        addr_d = {addr_q[23:AW], addr_inc};
                        sio_d  = nxt_byte[7:4];
                    end
                end
                S_WR: begin
                    if (cnt_q == 3'd0) begin
                        nib_d = i_mem_sio;
                        cnt_d = 3'd1;
                    end else begin
                        we     = 1'b1;
                        cnt_d  = 3'd0;
                        addr_d = {addr_q[23:AW], addr_inc};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state_q <= S_CMD;
            cnt_q   <= 3'd0;
            addr_q  <= 24'd0;
            nib_q   <= 4'h0;
            rd_q    <= 1'b0;
            sio_q   <= 4'h0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            nib_q   <= nib_d;
            rd_q    <= rd_d;
            sio_q   <= sio_d;
            oe_q    <= oe_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge i_mem_gck) begin
        if (we) begin
            mem[addr_q[AW-1:0]] <= wdata;
        end
    end

    assign o_mem_sio    = sio_q;
    assign o_mem_sio_oe = oe_q;

endmodule
